multi_tick_gen: RTL and testbench

- Parametrised successor to the single-rate 1 Hz clock divider: NUM_CH independent tick channels from one 50 MHz clock.
- Per channel:
  - runtime-loadable divisor;
  - periodic or one-shot mode;
  - one-cycle tick pulse plus a square-wave output.
- Drives the minute/second clock counters and any other slow-rate enables.
- A global sync input phase-aligns all channels.

---
 rtl/multi_tick_gen.sv | 93 +++++++++
 tb/tb_multi_tick_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_tick_gen.sv
// NUM_CH independent tick generators sharing one clock: each channel has a loadable
// divisor, periodic or one-shot mode, a one-cycle tick and a square-wave output.
module multi_tick_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 26,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic              clk_50mhz,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] oneshot,
  input  logic [NUM_CH-1:0] div_load,
  input  logic [DIV_W-1:0]  div_value,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] busy
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0]  div_reg [NUM_CH];
  logic [DIV_W-1:0]  cnt     [NUM_CH];
  logic [DIV_W-1:0]  div_nxt [NUM_CH];
  logic [DIV_W-1:0]  cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] armed;
  logic [NUM_CH-1:0] armed_nxt;
  logic [NUM_CH-1:0] tick_nxt;
  logic [NUM_CH-1:0] sq_nxt;
  logic [NUM_CH-1:0] busy_nxt;
  logic [DIV_W-1:0]  load_div;

  // A zero divisor would never reach terminal count, so it behaves as divide-by-one.
  assign load_div = (div_value == '0) ? ONE : div_value;

  always_comb begin
    armed_nxt = armed;
    tick_nxt  = '0;
    sq_nxt    = sq;
    busy_nxt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      div_nxt[i] = div_load[i] ? load_div : div_reg[i];
      cnt_nxt[i] = cnt[i];
      if (!en[i]) begin
        cnt_nxt[i]   = '0;
        sq_nxt[i]    = 1'b0;
        armed_nxt[i] = 1'b0;
      end else if (div_load[i] || sync || (oneshot[i] && !en_q[i])) begin
        cnt_nxt[i] = '0;
        if (oneshot[i] && !en_q[i])
          armed_nxt[i] = 1'b1;
      end else if (!oneshot[i] || armed[i]) begin
        if (cnt[i] == div_reg[i] - ONE) begin
          cnt_nxt[i]  = '0;
          tick_nxt[i] = 1'b1;
          sq_nxt[i]   = ~sq[i];
          if (oneshot[i])
            armed_nxt[i] = 1'b0;
        end else begin
          cnt_nxt[i] = cnt[i] + ONE;
        end
      end
      busy_nxt[i] = oneshot[i] ? armed_nxt[i] : en[i];
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_reg[i] <= DEF_DIV;
        cnt[i]     <= '0;
      end
      en_q  <= '0;
      armed <= '0;
      tick  <= '0;
      sq    <= '0;
      busy  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_reg[i] <= div_nxt[i];
        cnt[i]     <= cnt_nxt[i];
      end
      en_q  <= en;
      armed <= armed_nxt;
      tick  <= tick_nxt;
      sq    <= sq_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Self-checking bench for multi_tick_gen: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a step-counting reference model.
module tb_multi_tick_gen;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 26;
  localparam int DEFAULT_DIV = 10;

  typedef struct packed {
    int   steps;
    logic armed;
    logic tick;
    logic sq;
    logic busy;
  } ch_t;

  logic              clk_50mhz = 1'b0;
  logic              reset_n   = 1'b0;
  logic [NUM_CH-1:0] en        = '0;
  logic [NUM_CH-1:0] oneshot   = '0;
  logic [NUM_CH-1:0] div_load  = '0;
  logic [DIV_W-1:0]  div_value = '0;
  logic              sync      = 1'b0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] busy;

  int checks = 0;
  int errors = 0;
  int first [NUM_CH];
  int total [NUM_CH];

  ch_t               m_ch    [NUM_CH];
  int                m_div   [NUM_CH];
  logic [NUM_CH-1:0] m_prev_en;

  multi_tick_gen #(
    .NUM_CH     (NUM_CH),
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .reset_n  (reset_n),
    .en       (en),
    .oneshot  (oneshot),
    .div_load (div_load),
    .div_value(div_value),
    .sync     (sync),
    .tick     (tick),
    .sq       (sq),
    .busy     (busy)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] o,
                               input logic [NUM_CH-1:0] l, input logic [DIV_W-1:0] v,
                               input logic s);
    en        = e;
    oneshot   = o;
    div_load  = l;
    div_value = v;
    sync      = s;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_50mhz);
  endtask

  // Records, per channel, how many ticks show up in the next n cycles and at which one first.
  task automatic watch(input int n);
    for (int c = 0; c < NUM_CH; c++) begin
      first[c] = 0;
      total[c] = 0;
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_50mhz);
      for (int c = 0; c < NUM_CH; c++)
        if (tick[c] === 1'b1) begin
          total[c]++;
          if (first[c] == 0) first[c] = k;
        end
    end
  endtask

  // Reference: a channel ticks on every d-th counting edge since its last restart.
  function automatic ch_t modelChannel(input ch_t cur, input int d, input logic e, input logic o,
                                       input logic ld, input logic sy, input logic pe);
    ch_t  n      = cur;
    logic rising = e && !pe;
    n.tick = 1'b0;
    if (!e) begin
      n.steps = 0;
      n.armed = 1'b0;
      n.sq    = 1'b0;
    end else begin
      if (o && rising) n.armed = 1'b1;
      if (ld || sy || (o && rising)) begin
        n.steps = 0;
      end else if (!o || n.armed) begin
        n.steps = n.steps + 1;
        if (n.steps % d == 0) begin
          n.tick = 1'b1;
          n.sq   = !n.sq;
          if (o) n.armed = 1'b0;
        end
      end
    end
    n.busy = o ? n.armed : e;
    return n;
  endfunction

  always @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_ch[c]  <= '0;
        m_div[c] <= DEFAULT_DIV;
      end
      m_prev_en <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_ch[c] <= modelChannel(m_ch[c], m_div[c], en[c], oneshot[c], div_load[c], sync, m_prev_en[c]);
        if (div_load[c])
          m_div[c] <= (div_value == '0) ? 1 : int'(div_value);
      end
      m_prev_en <= en;
    end
  end

  always @(negedge clk_50mhz) begin
    for (int c = 0; c < NUM_CH; c++) begin
      checkOutput($sformatf("model_tick[%0d]", c), 32'(tick[c]), 32'(m_ch[c].tick));
      checkOutput($sformatf("model_sq[%0d]", c),   32'(sq[c]),   32'(m_ch[c].sq));
      checkOutput($sformatf("model_busy[%0d]", c), 32'(busy[c]), 32'(m_ch[c].busy));
    end
  end

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      m_ch[c]  = '0;
      m_div[c] = DEFAULT_DIV;
    end
    m_prev_en = '0;

    step(3);
    reset_n = 1'b1;
    step(1);
    checkOutput("reset_tick", 32'(tick), 32'h0);
    checkOutput("reset_sq",   32'(sq),   32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);

    // Default divide-by-10 on channel 0.
    applyStimulus(4'b0001, 4'b0000, 4'b0000, '0, 1'b0);
    watch(10);
    checkOutput("t1_first_tick", first[0], 10);
    checkOutput("t1_tick_count_a", total[0], 1);
    checkOutput("t1_sq_after_tick", 32'(sq[0]), 1);
    watch(90);
    checkOutput("t1_tick_count_b", total[0], 9);
    checkOutput("t1_tick_spacing", first[0], 10);

    // Divide-by-3, load at terminal count, then divisor 0 clamped to 1.
    applyStimulus(4'b0000, 4'b0000, 4'b0010, DIV_W'(3), 1'b0);
    step(1);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, '0, 1'b0);
    watch(30);
    checkOutput("t2_tick_count", total[1], 10);
    checkOutput("t2_first_tick", first[1], 3);
    step(2);
    applyStimulus(4'b0010, 4'b0000, 4'b0010, DIV_W'(3), 1'b0);
    step(1);
    checkOutput("t2_load_suppress", 32'(tick[1]), 0);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, '0, 1'b0);
    watch(3);
    checkOutput("t2_after_load", first[1], 3);
    applyStimulus(4'b0010, 4'b0000, 4'b0010, '0, 1'b0);
    step(1);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, '0, 1'b0);
    watch(5);
    checkOutput("t2_div1_constant", total[1], 5);

    // One-shot divide-by-5 on channel 2, then retrigger.
    applyStimulus(4'b0000, 4'b0100, 4'b0100, DIV_W'(5), 1'b0);
    step(1);
    applyStimulus(4'b0100, 4'b0100, 4'b0000, '0, 1'b0);
    step(1);
    checkOutput("t3_busy_armed", 32'(busy[2]), 1);
    watch(49);
    checkOutput("t3_single_tick", total[2], 1);
    checkOutput("t3_first_tick", first[2], 5);
    checkOutput("t3_busy_done", 32'(busy[2]), 0);
    applyStimulus(4'b0000, 4'b0100, 4'b0000, '0, 1'b0);
    step(1);
    applyStimulus(4'b0100, 4'b0100, 4'b0000, '0, 1'b0);
    watch(10);
    checkOutput("t3_retrigger_count", total[2], 1);
    checkOutput("t3_retrigger_time", first[2], 6);

    // Two divide-by-4 channels started 2 cycles apart, aligned by sync.
    applyStimulus(4'b0000, 4'b0000, 4'b0011, DIV_W'(4), 1'b0);
    step(1);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, '0, 1'b0);
    step(2);
    applyStimulus(4'b0011, 4'b0000, 4'b0000, '0, 1'b0);
    step(10);
    applyStimulus(4'b0011, 4'b0000, 4'b0000, '0, 1'b1);
    step(1);
    applyStimulus(4'b0011, 4'b0000, 4'b0000, '0, 1'b0);
    watch(11);
    checkOutput("t4_ch0_first", first[0], 4);
    checkOutput("t4_ch1_first", first[1], 4);
    checkOutput("t4_ch0_count", total[0], 2);
    checkOutput("t4_ch1_count", total[1], 2);

    // Asynchronous reset mid-count, then restart at the default divisor.
    applyStimulus(4'b1111, 4'b0000, 4'b0000, '0, 1'b0);
    step(7);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t5_async_tick", 32'(tick), 32'h0);
    checkOutput("t5_async_sq",   32'(sq),   32'h0);
    checkOutput("t5_async_busy", 32'(busy), 32'h0);
    step(2);
    reset_n = 1'b1;
    watch(12);
    for (int c = 0; c < NUM_CH; c++)
      checkOutput($sformatf("t5_first_tick[%0d]", c), first[c], 10);
    checkOutput("t5_ch3_count", total[3], 1);

    // Drop channel 3 at cnt=7, then re-enable.
    step(5);
    applyStimulus(4'b0111, 4'b0000, 4'b0000, '0, 1'b0);
    step(1);
    checkOutput("t6_sq_cleared", 32'(sq[3]), 0);
    checkOutput("t6_busy_cleared", 32'(busy[3]), 0);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, '0, 1'b0);
    watch(12);
    checkOutput("t6_reenable_first", first[3], 10);

    // Randomized traffic; the per-cycle compare against the model does the checking.
    for (int it = 0; it < 3000; it++) begin
      logic [NUM_CH-1:0] e;
      logic [NUM_CH-1:0] o;
      logic [NUM_CH-1:0] l;
      e = en;
      o = oneshot;
      l = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 19) == 0) e[c] = ~e[c];
        if ($urandom_range(0, 99) == 0) o[c] = ~o[c];
        if ($urandom_range(0, 39) == 0) l[c] = 1'b1;
      end
      applyStimulus(e, o, l, DIV_W'($urandom_range(0, 7)), ($urandom_range(0, 59) == 0));
      if ($urandom_range(0, 699) == 0) begin
        #2 reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
      end else begin
        step(1);
      end
    end

    applyStimulus('0, '0, '0, '0, 1'b0);
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
